tag_issue: RTL



---
 rtl/tag_pkg.sv | 16 +
 rtl/tag_issue_if.sv | 25 ++
 rtl/tag_pick.sv | 27 ++
 rtl/tag_issue.sv | 105 ++++++++++
 4 files changed

// File: rtl/tag_pkg.sv
// Shared tag-allocator constants and types.
// The pool holds NTAGS = 2^TAG_W tags, and the out_cnt range is 0..NTAGS.
package tag_pkg;
   localparam int TAG_W = 4;
   localparam int CNT_W = TAG_W + 1;
   localparam int NTAGS = 1 << TAG_W;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [NTAGS-1:0] tag_map_t;

   typedef enum logic {
      IDLE,
      OFFER
   } issue_state_e;
endpackage

// File: rtl/tag_issue_if.sv
// Bundles the allocate, release and status signals of the tag issuer.
// The master modport is the issuer side; the slave modport is the consumer/retire side.
interface tag_issue_if;
   import tag_pkg::*;

   logic alloc_valid;
   tag_t alloc_tag;
   logic alloc_ready;
   logic rel_valid;
   tag_t rel_tag;
   logic rel_err;
   cnt_t out_cnt;
   logic all_busy;
   logic none_busy;

   modport master (
      output alloc_valid, alloc_tag, rel_err, out_cnt, all_busy, none_busy,
      input  alloc_ready, rel_valid, rel_tag
   );

   modport slave (
      input  alloc_valid, alloc_tag, rel_err, out_cnt, all_busy, none_busy,
      output alloc_ready, rel_valid, rel_tag
   );
endinterface

// File: rtl/tag_pick.sv
// Combinational finder: returns the first free tag, scanning upward from start and wrapping.
// No latency; with start tied to 0 it reduces to lowest-index priority.
module tag_pick
   import tag_pkg::*;
(
   input  tag_map_t free,
   input  tag_t     start,
   output logic     found,
   output tag_t     idx
);

   tag_t cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = start;
      for (int i = 0; i < NTAGS; i++) begin
         cand = start + tag_t'(i);
         if (!found && free[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/tag_issue.sv
// Free-list tag allocator: one staged tag is offered on valid/ready, at 1 tag/cycle; a released tag is re-offerable 2 cycles later.
// The staged tag holds under backpressure. Defining TAG_ISSUE_RR_EN switches lowest-index selection to round-robin.
module tag_issue
   import tag_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   tag_issue_if.master  bus
);

   issue_state_e state_q, state_d;
   tag_map_t     free_q, free_d;
   tag_t         stage_q, stage_d;
   cnt_t         cnt_q, cnt_d;
   logic         err_q, err_d;

   logic hs;
   logic rel_ok;
   logic pick_found;
   tag_t pick_idx;
   tag_t pick_start;

`ifdef TAG_ISSUE_RR_EN
   tag_t last_q, last_d;
   assign pick_start = last_q + tag_t'(1);
`else
   assign pick_start = '0;
`endif

   // The picker sees the bitmap before this cycle's release, so there is no same-cycle bypass.
   tag_pick u_pick (
      .free  (free_q),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign hs     = (state_q == OFFER) && bus.alloc_ready;
   assign rel_ok = bus.rel_valid && !free_q[bus.rel_tag]
                   && !((state_q == OFFER) && (stage_q == bus.rel_tag));

   always_comb begin
      state_d = state_q;
      free_d  = free_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      err_d   = bus.rel_valid && !rel_ok;
`ifdef TAG_ISSUE_RR_EN
      last_d  = last_q;
`endif

      if ((state_q == IDLE) || hs) begin
         if (pick_found) begin
            free_d[pick_idx] = 1'b0;
            stage_d          = pick_idx;
            state_d          = OFFER;
`ifdef TAG_ISSUE_RR_EN
            last_d           = pick_idx;
`endif
         end else begin
            state_d = IDLE;
         end
      end

      if (rel_ok) begin
         free_d[bus.rel_tag] = 1'b1;
      end

      case ({hs, rel_ok})
         2'b10:   cnt_d = cnt_q + cnt_t'(1);
         2'b01:   cnt_d = cnt_q - cnt_t'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         free_q  <= '1;
         stage_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef TAG_ISSUE_RR_EN
         last_q  <= '1;
`endif
      end else begin
         state_q <= state_d;
         free_q  <= free_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef TAG_ISSUE_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   assign bus.alloc_valid = (state_q == OFFER);
   assign bus.alloc_tag   = stage_q;
   assign bus.rel_err     = err_q;
   assign bus.out_cnt     = cnt_q;
   assign bus.all_busy    = (cnt_q == cnt_t'(NTAGS));
   assign bus.none_busy   = (cnt_q == '0);

endmodule
